// File: rtl/exec_pkg.sv
// Shared encodings for the EX stage: ALU operation codes, the multiply/divide
// iteration count and the muldiv FSM state encoding.
package exec_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_NOR   = 4'd5;
  localparam logic [3:0] ALU_SLT   = 4'd6;
  localparam logic [3:0] ALU_SLTU  = 4'd7;
  localparam logic [3:0] ALU_SLL   = 4'd8;
  localparam logic [3:0] ALU_SRL   = 4'd9;
  localparam logic [3:0] ALU_SRA   = 4'd10;
  localparam logic [3:0] ALU_LUI   = 4'd11;
  localparam logic [3:0] ALU_MULTU = 4'd12;
  localparam logic [3:0] ALU_DIVU  = 4'd13;
  localparam logic [3:0] ALU_MFHI  = 4'd14;
  localparam logic [3:0] ALU_MFLO  = 4'd15;

  localparam int MULDIV_CYCLES = 32;
  localparam int CNT_W         = $clog2(MULDIV_CYCLES);

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/execute_stage_muldiv_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit owning
// HI/LO. The first iteration is folded into the load edge so the operation
// takes IDLE + 31 BUSY cycles for 32 iterations, then one DONE cycle in which
// HI/LO are written.
module muldiv_unit
  import exec_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_div,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  md_state_e         state, state_next;
  logic [CNT_W-1:0]  count;
  logic [63:0]       acc;
  logic [31:0]       divisor;
  logic              div_mode;
  logic [31:0]       hi_q, lo_q;

  // One iteration. Multiply: {acc_hi, multiplier} shifts right, adding the
  // multiplicand into the upper half when the current multiplier bit is set.
  // Divide: {remainder, dividend} shifts left; a 33-bit trial remainder is
  // compared so that 2r+1 never overflows. Divisor 0 naturally yields all-ones
  // quotient and remainder equal to the dividend.
  function automatic logic [63:0] md_step(input logic [63:0] p, input logic [31:0] d,
                                          input logic div);
    logic [32:0] sum;
    logic [32:0] trial;
    logic [32:0] diff;
    if (div) begin
      trial = p[63:31];
      diff  = trial - {1'b0, d};
      if (trial >= {1'b0, d}) md_step = {diff[31:0], p[30:0], 1'b1};
      else                    md_step = {trial[31:0], p[30:0], 1'b0};
    end else begin
      sum     = {1'b0, p[63:32]} + (p[0] ? {1'b0, d} : 33'd0);
      md_step = {sum, p[31:1]};
    end
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= MD_IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE: if (start) state_next = MD_BUSY;
      MD_BUSY: if (count == CNT_W'(MULDIV_CYCLES - 1)) state_next = MD_DONE;
      MD_DONE: state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state == MD_BUSY);
    done = (state == MD_DONE);
  end

  // Iteration datapath, counter and HI/LO write-back
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      count    <= '0;
      divisor  <= '0;
      div_mode <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state)
        MD_IDLE: if (start) begin
          divisor  <= b;
          div_mode <= is_div;
          acc      <= md_step({32'd0, a}, b, is_div);
          count    <= CNT_W'(1);
        end
        MD_BUSY: begin
          acc   <= md_step(acc, divisor, div_mode);
          count <= count + CNT_W'(1);
        end
        MD_DONE: begin
          hi_q  <= acc[63:32];
          lo_q  <= acc[31:0];
          count <= '0;
        end
        default: count <= '0;
      endcase
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/execute_stage.sv
// MIPS-32 EX stage: inline ALU, destination select, EX/MEM register and an
// optional iterative multiply/divide unit with HI/LO.
// Build macro: EXEC_MULDIV_EN compiles in muldiv_unit, HI/LO and the stall.
module execute_stage
  import exec_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        WB,
  input  logic [2:0]        M,
  input  logic [3:0]        alu_op,
  input  logic              ALUSrc,
  input  logic              RegDst,
  input  logic [DATA_W-1:0] Dato1,
  input  logic [DATA_W-1:0] Dato2,
  input  logic [DATA_W-1:0] imm,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [DATA_W-1:0] jump_address,
  output logic              stall,
  output logic [2:0]        WB_out,
  output logic [2:0]        M_out,
  output logic [DATA_W-1:0] Alu_result,
  output logic [DATA_W-1:0] Dato2_out,
  output logic [4:0]        Direccion,
  output logic [DATA_W-1:0] jump_address_out
);

  logic        [DATA_W-1:0] op_b;
  logic signed [DATA_W-1:0] a_s, b_s;
  logic        [4:0]        shamt;
  logic        [DATA_W-1:0] alu_y;
  logic        [DATA_W-1:0] hi, lo;
  logic                     is_muldiv;
  logic                     bubble;

  assign op_b      = ALUSrc ? imm : Dato2;
  assign a_s       = Dato1;
  assign b_s       = op_b;
  assign shamt     = imm[10:6];
  assign is_muldiv = (alu_op == ALU_MULTU) || (alu_op == ALU_DIVU);

`ifdef EXEC_MULDIV_EN
  logic md_done;
  logic md_busy_unused;

  muldiv_unit u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (is_muldiv),
    .is_div (alu_op == ALU_DIVU),
    .a      (Dato1),
    .b      (Dato2),
    .busy   (md_busy_unused),
    .done   (md_done),
    .hi     (hi),
    .lo     (lo)
  );

  // Held low while in reset so upstream is never frozen by a stale op code.
  assign stall  = rst_n && is_muldiv && !md_done;
  assign bubble = stall;
`else
  assign hi     = '0;
  assign lo     = '0;
  assign stall  = 1'b0;
  assign bubble = is_muldiv;
`endif

  // ALU: combinational operation select; MULTU/DIVU produce 0 here
  always_comb begin
    alu_y = '0;
    case (alu_op)
      ALU_ADD:  alu_y = Dato1 + op_b;
      ALU_SUB:  alu_y = Dato1 - op_b;
      ALU_AND:  alu_y = Dato1 & op_b;
      ALU_OR:   alu_y = Dato1 | op_b;
      ALU_XOR:  alu_y = Dato1 ^ op_b;
      ALU_NOR:  alu_y = ~(Dato1 | op_b);
      ALU_SLT:  alu_y = {31'd0, a_s < b_s};
      ALU_SLTU: alu_y = {31'd0, Dato1 < op_b};
      ALU_SLL:  alu_y = op_b << shamt;
      ALU_SRL:  alu_y = op_b >> shamt;
      ALU_SRA:  alu_y = b_s >>> shamt;
      ALU_LUI:  alu_y = {op_b[15:0], 16'd0};
      ALU_MFHI: alu_y = hi;
      ALU_MFLO: alu_y = lo;
      default:  alu_y = '0;
    endcase
  end

  // EX/MEM register: bubble while stalled, muldiv retires with WB cleared
  always_ff @(posedge clk) begin
    if (!rst_n || bubble) begin
      WB_out           <= '0;
      M_out            <= '0;
      Alu_result       <= '0;
      Dato2_out        <= '0;
      Direccion        <= '0;
      jump_address_out <= '0;
    end else begin
      WB_out           <= is_muldiv ? 3'd0 : WB;
      M_out            <= M;
      Alu_result       <= alu_y;
      Dato2_out        <= Dato2;
      Direccion        <= RegDst ? rd : rt;
      jump_address_out <= jump_address;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: expected EX/MEM contents are queued when
// an instruction is driven and compared after the capturing edge.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  WB, M;
  logic [3:0]  alu_op;
  logic        ALUSrc, RegDst;
  logic [31:0] Dato1, Dato2, imm, jump_address;
  logic [4:0]  rt, rd;
  logic        stall;
  logic [2:0]  WB_out, M_out;
  logic [31:0] Alu_result, Dato2_out, jump_address_out;
  logic [4:0]  Direccion;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0]  wb;
    logic [2:0]  m;
    logic [31:0] res;
    logic [31:0] d2;
    logic [4:0]  dir;
    logic [31:0] ja;
  } exp_t;

  exp_t sb[$];

  execute_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .WB               (WB),
    .M                (M),
    .alu_op           (alu_op),
    .ALUSrc           (ALUSrc),
    .RegDst           (RegDst),
    .Dato1            (Dato1),
    .Dato2            (Dato2),
    .imm              (imm),
    .rt               (rt),
    .rd               (rd),
    .jump_address     (jump_address),
    .stall            (stall),
    .WB_out           (WB_out),
    .M_out            (M_out),
    .Alu_result       (Alu_result),
    .Dato2_out        (Dato2_out),
    .Direccion        (Direccion),
    .jump_address_out (jump_address_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [2:0] wb, input logic [2:0] m,
                       input logic src, input logic dst, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] im, input logic [4:0] t,
                       input logic [4:0] d, input logic [31:0] ja);
    alu_op = op; WB = wb; M = m; ALUSrc = src; RegDst = dst;
    Dato1 = d1; Dato2 = d2; imm = im; rt = t; rd = d; jump_address = ja;
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({tag, "_wb"},  WB_out, e.wb);
      check({tag, "_m"},   M_out, e.m);
      check({tag, "_res"}, Alu_result, e.res);
      check({tag, "_d2"},  Dato2_out, e.d2);
      check({tag, "_dir"}, Direccion, e.dir);
      check({tag, "_ja"},  jump_address_out, e.ja);
    end
  endtask

  // Single-cycle op: push expectation, clock it through, compare.
  task automatic run_op(input string tag, input logic [3:0] op, input logic src,
                        input logic dst, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] im, input logic [31:0] exp_res);
    logic [4:0]  t  = 5'(3 + op);
    logic [4:0]  d  = 5'(17 + op);
    logic [31:0] ja = 32'h0040_0000 + {28'd0, op};
    drive(op, 3'b101, 3'b000, src, dst, d1, d2, im, t, d, ja);
    sb.push_back('{wb: 3'b101, m: 3'b000, res: exp_res, d2: d2,
                   dir: dst ? d : t, ja: ja});
    #1 check({tag, "_stall"}, stall, 0);
    @(posedge clk); #1;
    pop_compare(tag);
  endtask

  // MULTU/DIVU issue; returns with the following instruction slot open.
  task automatic run_muldiv(input string tag, input logic div, input logic [31:0] a,
                            input logic [31:0] b);
    int cnt = 0;
    drive(div ? 4'd13 : 4'd12, 3'b011, 3'b000, 1'b0, 1'b1, a, b, 32'd0, 5'd8, 5'd9,
          32'h1234_5678);
    #1;
`ifdef EXEC_MULDIV_EN
    while (stall && cnt < 100) begin
      @(posedge clk); #1;
      if (cnt == 4) check({tag, "_bubble_wb"}, WB_out, 0);
      #1;
      cnt++;
    end
    check({tag, "_stall_cycles"}, cnt, 32);
    sb.push_back('{wb: 3'b000, m: 3'b000, res: 32'd0, d2: b, dir: 5'd9,
                   ja: 32'h1234_5678});
`else
    check({tag, "_stall"}, stall, 0);
    sb.push_back('{wb: 3'b000, m: 3'b000, res: 32'd0, d2: 32'd0, dir: 5'd0, ja: 32'd0});
`endif
    @(posedge clk); #1;
    pop_compare(tag);
  endtask

  task automatic check_muldiv(input string tag, input logic div, input logic [31:0] a,
                              input logic [31:0] b);
    logic [63:0] prod;
    logic [31:0] ehi, elo;
    if (div) begin
      elo = (b == 0) ? 32'hFFFF_FFFF : a / b;
      ehi = (b == 0) ? a : a % b;
    end else begin
      prod = {32'd0, a} * {32'd0, b};
      ehi  = prod[63:32];
      elo  = prod[31:0];
    end
`ifndef EXEC_MULDIV_EN
    ehi = 32'd0;
    elo = 32'd0;
`endif
    run_muldiv(tag, div, a, b);
    run_op({tag, "_mfhi"}, 4'd14, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0, ehi);
    run_op({tag, "_mflo"}, 4'd15, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0, elo);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'd0, 3'd0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", stall, 0);
    check("rst_wb",    WB_out, 0);
    check("rst_res",   Alu_result, 0);
    check("rst_dir",   Direccion, 0);
    rst_n = 1'b1;

    run_op("add_wrap", 4'd0,  1'b1, 1'b1, 32'h7FFF_FFFF, 32'h0,        32'd1, 32'h8000_0000);
    run_op("sub",      4'd1,  1'b0, 1'b1, 32'd5,         32'd7,        32'd0, 32'hFFFF_FFFE);
    run_op("and",      4'd2,  1'b0, 1'b0, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'd0, 32'h00F0_F000);
    run_op("or",       4'd3,  1'b0, 1'b0, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'd0, 32'hFFF0_FFF0);
    run_op("xor",      4'd4,  1'b0, 1'b0, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'd0, 32'hFF00_0FF0);
    run_op("nor",      4'd5,  1'b0, 1'b0, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'd0, 32'h000F_000F);
    run_op("slt",      4'd6,  1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1,        32'd0, 32'd1);
    run_op("sltu",     4'd7,  1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1,        32'd0, 32'd0);
    run_op("sll",      4'd8,  1'b0, 1'b1, 32'd0, 32'h8000_0001, 32'h0000_0100, 32'h0000_0010);
    run_op("srl",      4'd9,  1'b0, 1'b1, 32'd0, 32'h8000_0001, 32'h0000_0100, 32'h0800_0000);
    run_op("sra",      4'd10, 1'b0, 1'b1, 32'd0, 32'h8000_0001, 32'h0000_0100, 32'hF800_0000);
    run_op("lui",      4'd11, 1'b1, 1'b0, 32'd0, 32'd0,         32'h0000_1234, 32'h1234_0000);

    // Store word: memwrite, rt destination, store data is Dato2 not imm.
    drive(4'd0, 3'b000, 3'b010, 1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'd8, 5'd6, 5'd7, 32'd0);
    sb.push_back('{wb: 3'b000, m: 3'b010, res: 32'h108, d2: 32'hDEAD_BEEF, dir: 5'd6,
                   ja: 32'd0});
    @(posedge clk); #1;
    pop_compare("sw");

    check_muldiv("multu",  1'b0, 32'h0001_2345, 32'h0001_0000);
    check_muldiv("multu2", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_muldiv("divu",   1'b1, 32'd100, 32'd7);
    check_muldiv("divu0",  1'b1, 32'd5, 32'd0);
    // Back-to-back: second op issues directly after the DONE cycle.
    run_muldiv("b2b_a", 1'b0, 32'd3, 32'd4);
    check_muldiv("b2b_b", 1'b1, 32'hFFFF_FFF0, 32'd16);

    // Reset ten iterations into a divide.
    drive(4'd13, 3'b011, 3'b000, 1'b0, 1'b1, 32'd100, 32'd7, 32'd0, 5'd8, 5'd9, 32'h55);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1 check("rstmid_stall_in_reset", stall, 0);
    @(posedge clk); #1;
    drive(4'd0, 3'b000, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rstmid_stall", stall, 0);
    check("rstmid_wb",  WB_out, 0);
    check("rstmid_res", Alu_result, 0);
    check("rstmid_ja",  jump_address_out, 0);
    run_op("rstmid_mflo", 4'd15, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0);
    run_op("rstmid_mfhi", 4'd14, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Pipeline EX stage of the MIPS-32 core, sitting between the ID/EX register and the memory stage. It performs the ALU operation, selects the destination register, and runs an iterative unsigned multiply/divide unit that owns the HI/LO registers. It registers everything the memory stage consumes (WB, M, ALU result, store data, destination, jump address) in an internal EX/MEM register. While a multiply/divide is in flight it raises a stall to freeze the front of the pipe.

## Interface
Parameters:
- none; widths and encodings come from `exec_pkg`

Ports:
- clk  in  1  pipeline clock; all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- WB  in  3  writeback control from ID/EX; passed through
- M  in  3  memory control from ID/EX; [1]=memwrite, [0]=memread; passed through
- alu_op  in  4  decoded operation (encodings under Operation)
- ALUSrc  in  1  1: operand B = imm; 0: operand B = Dato2
- RegDst  in  1  1: destination = rd; 0: destination = rt
- Dato1, Dato2  in  32  register operands rs, rt
- imm  in  32  sign-extended immediate; shamt = imm[10:6]
- rt, rd  in  5  candidate destinations
- jump_address  in  32  passed through
- stall  out  1  1 while a MULTU/DIVU is executing; upstream holds ID/EX and PC
- WB_out, M_out  out  3  registered controls to the memory stage
- Alu_result  out  32  registered result / memory address
- Dato2_out  out  32  registered store data (Dato2, never imm)
- Direccion  out  5  registered destination register
- jump_address_out  out  32  registered

## Operation
- Encodings: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI (B<<16), 12 MULTU, 13 DIVU, 14 MFHI, 15 MFLO.
- Shifts operate on operand B by shamt. ADD and SUB wrap mod 2^32, with no overflow trap.
- MULTU: {HI,LO} = Dato1*Dato2, a 64-bit unsigned product computed by shift-add.
- DIVU: restoring division, LO = quotient and HI = remainder. A divisor of 0 gives LO=0xFFFFFFFF and HI=Dato1.
- The muldiv_unit has states IDLE → BUSY (32 iterations) → DONE (one cycle, HI/LO written) → IDLE.
- Stall behaviour:
  - stall = (alu_op is MULTU/DIVU) && state != DONE. It is combinational, so it rises in the issue cycle.
  - While stall=1, EX/MEM loads a bubble: WB_out=0, M_out=0, other fields don't-care but loaded with 0.
- In the DONE cycle, EX/MEM captures the MULTU/DIVU instruction itself with WB_out forced to 0, since it writes no GPR.
- MFHI/MFLO read the current HI/LO. No hazard exists because of the stall.

## Timing
- Reset (rst_n=0 at an edge):
  - All EX/MEM outputs go to 0.
  - HI=LO=0, state=IDLE, iteration counter=0.
  - stall=0 during reset.
- A reset mid-operation aborts the unit, and HI/LO are left at 0.
- Non-muldiv ops have 1-cycle latency: inputs at edge n appear on outputs after edge n+1.
- MULTU/DIVU:
  - Issue cycle is c0. stall is high for c0..c31 (32 cycles) and low in c32 (DONE).
  - HI/LO update at the end of c32.
  - An MFHI issued next sees the new value.
- Back-to-back MULTU/DIVU: the second instruction enters at c33 and starts from IDLE. There is no lost cycle beyond DONE.

## Configuration
- `EXEC_MULDIV_EN` defined: the muldiv_unit, HI/LO and stall logic are compiled in, as above.
- Undefined:
  - No muldiv hardware; stall tied to 0.
  - MULTU/DIVU pass through as bubbles (WB_out=0, M_out=0).
  - MFHI/MFLO return 0.

## Structure
- `exec_pkg`: the alu_op localparams, `MULDIV_CYCLES=32`, and the muldiv state enum encoding.
- Sub-module `muldiv_unit`:
  - Inputs: clk, rst_n, start, is_div, a, b.
  - Outputs: busy, done, hi, lo.
  - It contains the counter, the 64-bit shift register and the FSM.
- The ALU stays inline as a combinational case. The EX/MEM register is inline too.

## Test plan
- ADD Dato1=0x7FFFFFFF, imm=1, ALUSrc=1 → Alu_result=0x80000000 one cycle later. SLT -1 vs 1 → 1; SLTU → 0.
- MULTU 0x00012345 × 0x00010000 → stall high exactly 32 cycles. Then MFHI → 0x00000001, MFLO → 0x23450000.
- DIVU 100/7 → LO=14, HI=2. DIVU 5/0 → LO=0xFFFFFFFF, HI=5.
- SW: RegDst=0, M=3'b010, Dato2=0xDEADBEEF, imm=8, Dato1=0x100 → Alu_result=0x108, Dato2_out=0xDEADBEEF, Direccion=rt.
- rst_n=0 at iteration 10 of a DIVU → next cycle stall=0, all outputs 0. A following MFLO returns 0.
- Build without `EXEC_MULDIV_EN`: MULTU issued → stall never rises and WB_out=0. MFHI → 0.
